// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// frame geometry and the word-to-byte-address helper.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5,
      ST_CHK   = 3'd6
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   // 32-bit byte address of word idx; wraps modulo 2**32 by construction.
   function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                  input logic [15:0] idx);
      return base + {14'b0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs big-endian bytes into a 32-bit word; o_word_valid marks the cycle the
// fourth byte is accepted. i_clear drops any partial word.
module byte_packer
   import loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  r_cnt;
   logic [31:0] r_word;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_clear) begin
         r_cnt  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_byte_valid) begin
         r_cnt  <= r_cnt + 2'd1;
         r_word <= {r_word[23:0], i_byte};
      end
   end

   assign o_word       = r_word;
   assign o_word_valid = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, holding
// the CPU in reset until loaded. IMEM_LOADER_CHECKSUM_EN adds an XOR trailer check.
module imem_boot_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_in_data,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_cpu_hold,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [15:0] o_word_count
);

   state_t      r_state, w_next;
   logic [7:0]  r_hdr_hi;
   logic        r_hdr_cnt;
   logic [15:0] r_len;
   logic [15:0] r_word_count;

   logic        w_xfer, w_start_ok, w_hdr_last, w_len_zero, w_len_big, w_last;
   logic        w_pack_valid;
   logic [15:0] w_len;
   logic [31:0] w_word;

   assign w_xfer     = i_in_valid & o_in_ready;
   assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE) |
                                  (r_state == ST_ERR));
   assign w_hdr_last = (r_hdr_cnt == 1'(HDR_BYTES - 1));
   assign w_len      = {r_hdr_hi, i_in_data};
   assign w_len_zero = (w_len == 16'd0);
   assign w_len_big  = ({16'd0, w_len} > (32'd1 << ADDR_WIDTH));
   assign w_last     = ((r_word_count + 16'd1) == r_len);

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: if (w_start_ok) w_next = ST_LEN;
         ST_LEN: begin
            if (w_xfer && w_hdr_last) begin
               if (w_len_zero)     w_next = ST_DONE;
               else if (w_len_big) w_next = ST_ERR;
               else                w_next = ST_DATA;
            end
         end
         ST_DATA: if (w_pack_valid) w_next = ST_WRITE;
         ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = w_last ? ST_CHK : ST_DATA;
`else
            w_next = w_last ? ST_DONE : ST_DATA;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: if (w_xfer) w_next = (i_in_data == r_csum) ? ST_DONE : ST_ERR;
`endif
         default: w_next = ST_IDLE;
      endcase
   end

   // A start sampled in DONE re-holds the CPU in that same cycle.
   always_comb begin
      o_in_ready = (r_state == ST_LEN) | (r_state == ST_DATA) | (r_state == ST_CHK);
      o_mem_we   = (r_state == ST_WRITE);
      o_busy     = (r_state == ST_LEN) | (r_state == ST_DATA) |
                   (r_state == ST_WRITE) | (r_state == ST_CHK);
      o_done     = (r_state == ST_DONE) & ~i_start;
      o_cpu_hold = ~((r_state == ST_DONE) & ~i_start);
      o_err      = (r_state == ST_ERR);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hdr_hi     <= 8'd0;
         r_hdr_cnt    <= 1'b0;
         r_len        <= 16'd0;
         r_word_count <= 16'd0;
      end else if (w_start_ok) begin
         r_hdr_cnt    <= 1'b0;
         r_word_count <= 16'd0;
      end else begin
         if ((r_state == ST_LEN) && w_xfer) begin
            if (!w_hdr_last) begin
               r_hdr_hi  <= i_in_data;
               r_hdr_cnt <= 1'b1;
            end else begin
               r_len <= w_len;
            end
         end
         if (r_state == ST_WRITE) r_word_count <= r_word_count + 16'd1;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                           r_csum <= 8'd0;
      else if (w_start_ok)                    r_csum <= 8'd0;
      else if ((r_state == ST_DATA) && w_xfer) r_csum <= r_csum ^ i_in_data;
   end
`endif

   byte_packer u_packer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (w_start_ok),
      .i_byte_valid (w_xfer && (r_state == ST_DATA)),
      .i_byte       (i_in_data),
      .o_word       (w_word),
      .o_word_valid (w_pack_valid)
   );

   assign o_mem_wdata  = w_word;
   assign o_mem_addr   = word_byte_addr(BASE_ADDR, r_word_count);
   assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as frames are
// sent and popped by a monitor on every mem_we cycle. Covers IMEM_LOADER_CHECKSUM_EN.
module tb_imem_boot_loader;

   localparam int          AW   = 4;
   localparam logic [31:0] BASE = 32'h0;

   logic        clk, rst_n, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, cpu_hold, busy, done, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] word_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] w_buf [0:15];

   imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_in_data    (in_data),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_cpu_hold   (cpu_hold),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err),
      .o_word_count (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("[TB] ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (rst_n && mem_we) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                     mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
         end
         check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit tog);
      int c = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (c >= 50) fail_now("send_byte");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (tog) @(posedge clk);
   endtask

   task automatic pulse_start;
      logic was_done;
      @(negedge clk);
      was_done = done;
      start = 1'b1;
      #1;
      if (was_done) begin
         check("reload_hold_same_cycle", {31'd0, cpu_hold}, 32'd1);
         check("reload_done_drops", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end;
      int c = 0;
      while (!(done || err) && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (c >= 50) fail_now("wait_end");
   endtask

   task automatic load(input int n, input bit tog, input bit bad_csum);
      logic [15:0] nn;
      logic [7:0]  b, csum;
      nn   = 16'(n);
      csum = 8'd0;
      pulse_start();
      send_byte(nn[15:8], tog);
      send_byte(nn[7:0], tog);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{BASE + 32'(4 * i), w_buf[i]});
         for (int k = 3; k >= 0; k--) begin
            b    = w_buf[i][8*k +: 8];
            csum = csum ^ b;
            send_byte(b, tog);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (n > 0) send_byte(bad_csum ? (csum ^ 8'h01) : csum, tog);
`else
      if (bad_csum) $display("[TB] note: checksum trailer not used in this build");
`endif
      wait_end();
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_addr", mem_addr, BASE);
      check("rst_status", {29'd0, busy, done, err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Two-word image.
      w_buf[0] = 32'h20080005;
      w_buf[1] = 32'h0000000C;
      load(2, 1'b0, 1'b0);
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      check("t1_word_count", {16'd0, word_count}, 32'd2);

      // Empty image: DONE straight after the header, no writes.
      load(0, 1'b0, 1'b0);
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_word_count", {16'd0, word_count}, 32'd0);

      // Oversize header for a 16-word memory.
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("t3_in_ready", {31'd0, in_ready}, 32'd0);
      pulse_start();
      check("t3_err_cleared", {31'd0, err}, 32'd0);
      check("t3_busy_len", {30'd0, busy, in_ready}, 32'd3);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      check("t3_recover_done", {31'd0, done}, 32'd1);

      // Three words with in_valid toggling every cycle.
      w_buf[0] = 32'h11223344;
      w_buf[1] = 32'h55667788;
      w_buf[2] = 32'h99AABBCC;
      load(3, 1'b1, 1'b0);
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_word_count", {16'd0, word_count}, 32'd3);

      // Largest legal image: exactly 2**AW words.
      for (int i = 0; i < 16; i++) w_buf[i] = 32'hA5000000 | 32'(i * 32'h00010203);
      load(16, 1'b0, 1'b0);
      check("tmax_done", {31'd0, done}, 32'd1);
      check("tmax_word_count", {16'd0, word_count}, 32'd16);

      // Reset in the middle of a word.
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_mem_we", {31'd0, mem_we}, 32'd0);
      check("t5_mem_addr", mem_addr, BASE);
      check("t5_mem_wdata", mem_wdata, 32'd0);
      check("t5_hold_ready", {30'd0, cpu_hold, in_ready}, 32'd2);
      check("t5_status", {29'd0, busy, done, err}, 32'd0);
      check("t5_word_count", {16'd0, word_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      w_buf[0] = 32'hCAFEF00D;
      load(1, 1'b0, 1'b0);
      check("t5_reload_done", {31'd0, done}, 32'd1);
      check("t5_reload_count", {16'd0, word_count}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // XOR(AA,55,00,FF) = 00.
      w_buf[0] = 32'hAA5500FF;
      load(1, 1'b0, 1'b0);
      check("t6_good_done", {31'd0, done}, 32'd1);
      load(1, 1'b0, 1'b1);
      check("t6_bad_err", {31'd0, err}, 32'd1);
      check("t6_bad_hold", {31'd0, cpu_hold}, 32'd1);
      check("t6_bad_count", {16'd0, word_count}, 32'd1);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
